alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Byte-stream command front end for the registered ALU. It collects a command frame of up to three bytes (opcode, operand A, operand B) from a receive stream and issues a one-cycle ALU_EN. It then waits for the ALU's OUT_VALID and returns the result byte over a valid/ready transmit handshake. It sits between the serial/system-control byte path and the ALU, and is the only master of the ALU's inputs.

Parameters:
DATA_WIDTH, 8, width of RX bytes, operands, ALU result and TX data
FUN_WIDTH, 4, width of ALU function code
TIMEOUT_CYC, 15, max cycles waited in WAIT_RES before error (used only with ALU_SEQ_TIMEOUT_EN)
ERR_CODE, 8'hFF, TX_DATA value sent on timeout

Ports:
CLK  in  1  system clock; all logic rising-edge
RST  in  1  synchronous, active-high reset
RX_DATA  in  DATA_WIDTH  incoming command byte
RX_VALID  in  1  single-cycle strobe: RX_DATA valid this cycle
ALU_A  out  DATA_WIDTH  operand A to ALU
ALU_B  out  DATA_WIDTH  operand B to ALU
ALU_FUN  out  FUN_WIDTH  function code to ALU
ALU_EN  out  1  one-cycle ALU enable
ALU_OUT  in  DATA_WIDTH  ALU result
OUT_VALID  in  1  ALU result valid
TX_DATA  out  DATA_WIDTH  result byte
TX_VALID  out  1  result valid; held until TX_READY
TX_READY  in  1  downstream accepts TX_DATA
TX_ERR  out  1  qualifies TX_DATA as ERR_CODE (timeout)
BUSY  out  1  high whenever state != IDLE
RX_DROP  out  1  one-cycle pulse: RX byte arrived while not accepting

Behaviour:
- One clock. Reset is synchronous and active-high: RST sampled high on a CLK edge -> state IDLE. All outputs 0 after reset: ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, TX_ERR, BUSY, RX_DROP. Stored operands cleared; timeout counter cleared.
- Reset mid-frame or mid-WAIT aborts: no ALU_EN and no TX follow. A pending TX_VALID drops.
- Opcode byte format: [FUN_WIDTH-1:0] = function; bit 7 = REUSE; bits 6:4 ignored.
- States: IDLE, GET_A, GET_B, EXEC, WAIT_RES, SEND.
- IDLE: on RX_VALID, latch function into ALU_FUN. If REUSE=1 -> EXEC, keeping the stored A/B. Otherwise -> GET_A.
- GET_A: on RX_VALID, latch ALU_A -> GET_B.
- GET_B: on RX_VALID, latch ALU_B -> EXEC.
- EXEC: ALU_EN=1 for exactly this cycle -> WAIT_RES.
- WAIT_RES: on OUT_VALID=1, register ALU_OUT into TX_DATA, TX_ERR=0 -> SEND. OUT_VALID is ignored in all other states.
- SEND: TX_VALID=1; TX_DATA/TX_ERR held stable until a cycle with TX_READY=1. In that cycle the transfer completes; next cycle TX_VALID=0 and state -> IDLE.
- If TX_READY is already high on SEND entry, TX_VALID is high for exactly one cycle.
- ALU_A/ALU_B/ALU_FUN hold their values from latch until the next latch. They are never changed during EXEC/WAIT_RES.
- Latency: last operand byte accepted at edge N -> ALU_EN high in cycle N+1. Earliest TX_VALID is one cycle after OUT_VALID is sampled.
- RX_VALID in EXEC, WAIT_RES or SEND: byte discarded, RX_DROP pulses 1 cycle, state unaffected.
- No frame timeout between bytes: a partial frame waits indefinitely.
- BUSY is a registered decode of state.

Optional Feature:
Macro ALU_SEQ_TIMEOUT_EN.
- Defined: counter cleared on EXEC entry, increments each WAIT_RES cycle. If OUT_VALID has not arrived after TIMEOUT_CYC WAIT_RES cycles -> SEND with TX_DATA=ERR_CODE, TX_ERR=1. OUT_VALID in the same cycle as expiry wins, giving a normal result.
- Undefined: no counter; WAIT_RES waits indefinitely; TX_ERR tied 0.

Decomposition:
- Package alu_seq_pkg: state encoding constants, REUSE bit index (7), default ERR_CODE, FUN_WIDTH default.
- One natural sub-module: alu_seq_timeout (loadable down-counter with expire flag), instantiated only under ALU_SEQ_TIMEOUT_EN.
- Everything else is a single FSM plus registers.

Test Plan:
- RX 0x00, 0x05, 0x02 (add), TX_READY=1 -> one ALU_EN pulse with A=5, B=2, FUN=0. Then TX_DATA=7, TX_ERR=0, TX_VALID for 1 cycle, BUSY back to 0.
- After the above, RX 0x81 (REUSE, sub) alone -> ALU_EN with A=5, B=2, FUN=1, no operand bytes consumed; TX_DATA=3.
- RX 0x02, 0x05, 0x02 (mul) with TX_READY=0 for 5 cycles -> TX_VALID held, TX_DATA=10 stable all 5 cycles. Completes on first TX_READY=1.
- RX byte during WAIT_RES -> RX_DROP 1-cycle pulse, ALU_A/B/FUN unchanged, result still correct.
- RST high after opcode and A bytes -> all outputs 0 next cycle. Then frame 0x0C, 0x05, 0x02 (shift right) yields TX_DATA=2.
- With ALU_SEQ_TIMEOUT_EN: ALU OUT_VALID forced 0 -> TX_VALID with TX_DATA=0xFF, TX_ERR=1 after exactly 15 WAIT_RES cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: state encoding, opcode
// field positions and default configuration values.
package alu_seq_pkg;

  localparam int          DATA_WIDTH_D  = 8;
  localparam int          FUN_WIDTH_D   = 4;
  localparam int          TIMEOUT_CYC_D = 15;
  localparam int          REUSE_BIT     = 7;
  localparam logic [7:0]  ERR_CODE_D    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_EXEC     = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_SEND     = 3'd5
  } state_e;

  function automatic logic rx_accepting(input state_e s);
    return (s == ST_IDLE) || (s == ST_GET_A) || (s == ST_GET_B);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the sequencer's byte-stream, ALU and transmit signals.
// slave = sequencer view, master = surrounding system view.
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4
) ();

  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic [DATA_WIDTH-1:0] ALU_A;
  logic [DATA_WIDTH-1:0] ALU_B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  ALU_EN;
  logic [DATA_WIDTH-1:0] ALU_OUT;
  logic                  OUT_VALID;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;
  logic                  TX_ERR;
  logic                  BUSY;
  logic                  RX_DROP;

  modport slave (
    input  RX_DATA, RX_VALID, ALU_OUT, OUT_VALID, TX_READY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, TX_ERR, BUSY, RX_DROP
  );

  modport master (
    output RX_DATA, RX_VALID, ALU_OUT, OUT_VALID, TX_READY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, TX_ERR, BUSY, RX_DROP
  );

endinterface

// File: rtl/alu_seq_timeout.sv
// Loadable down-counter bounding the wait for the ALU result; o_expire marks
// the last permitted wait cycle.
module alu_seq_timeout #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] r_cnt;

  // Reload on entry to execute, count down while waiting for the result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_expire = i_dec && (r_cnt == ONE);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command front end for the registered ALU.
// Optional result timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int                  DATA_WIDTH  = DATA_WIDTH_D,
  parameter int                  FUN_WIDTH   = FUN_WIDTH_D,
  parameter int                  TIMEOUT_CYC = TIMEOUT_CYC_D,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE  = DATA_WIDTH'(ERR_CODE_D)
) (
  input  logic              CLK,
  input  logic              RST,
  alu_cmd_sequencer_if.slave io_bus
);

  state_e                r_state;
  state_e                w_next_state;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [FUN_WIDTH-1:0]  r_alu_fun;
  logic                  r_alu_en;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;
  logic                  r_tx_err;
  logic                  r_busy;
  logic                  r_rx_drop;
  logic                  w_expire;

`ifdef ALU_SEQ_TIMEOUT_EN
  alu_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_load   (r_state == ST_EXEC),
    .i_dec    (r_state == ST_WAIT_RES),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // Next-state decode of the command frame FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.RX_VALID) begin
          w_next_state = io_bus.RX_DATA[REUSE_BIT] ? ST_EXEC : ST_GET_A;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GET_A:    w_next_state = io_bus.RX_VALID ? ST_GET_B : ST_GET_A;
      ST_GET_B:    w_next_state = io_bus.RX_VALID ? ST_EXEC  : ST_GET_B;
      ST_EXEC:     w_next_state = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (io_bus.OUT_VALID || w_expire) begin
          w_next_state = ST_SEND;
        end else begin
          w_next_state = ST_WAIT_RES;
        end
      end
      ST_SEND:     w_next_state = io_bus.TX_READY ? ST_IDLE : ST_SEND;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the upcoming state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_alu_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_rx_drop  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_alu_en   <= (w_next_state == ST_EXEC);
      r_busy     <= (w_next_state != ST_IDLE);
      r_tx_valid <= (w_next_state == ST_SEND);
      r_rx_drop  <= io_bus.RX_VALID && !rx_accepting(r_state);
    end
  end

  // Operand/function capture and result capture; OUT_VALID wins over expiry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_tx_data <= '0;
      r_tx_err  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && io_bus.RX_VALID) begin
        r_alu_fun <= io_bus.RX_DATA[FUN_WIDTH-1:0];
      end
      if ((r_state == ST_GET_A) && io_bus.RX_VALID) begin
        r_alu_a <= io_bus.RX_DATA;
      end
      if ((r_state == ST_GET_B) && io_bus.RX_VALID) begin
        r_alu_b <= io_bus.RX_DATA;
      end
      if (r_state == ST_WAIT_RES) begin
        if (io_bus.OUT_VALID) begin
          r_tx_data <= io_bus.ALU_OUT;
          r_tx_err  <= 1'b0;
        end else if (w_expire) begin
          r_tx_data <= ERR_CODE;
          r_tx_err  <= 1'b1;
        end
      end
    end
  end

  assign io_bus.ALU_A    = r_alu_a;
  assign io_bus.ALU_B    = r_alu_b;
  assign io_bus.ALU_FUN  = r_alu_fun;
  assign io_bus.ALU_EN   = r_alu_en;
  assign io_bus.TX_DATA  = r_tx_data;
  assign io_bus.TX_VALID = r_tx_valid;
  assign io_bus.TX_ERR   = r_tx_err;
  assign io_bus.BUSY     = r_busy;
  assign io_bus.RX_DROP  = r_rx_drop;

endmodule
